// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter for the 32x32 regfile. After each reset it runs a zero-clear sweep.
// Optional macro REGFILE_WB_BYPASS_EN forwards the in-flight write data onto both read ports.
module regfile_write_arbiter #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              ctrl_writeEn,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  input  logic [DATA_W-1:0] data_readRegA,
  input  logic [DATA_W-1:0] data_readRegB,
  output logic [DATA_W-1:0] data_outA,
  output logic [DATA_W-1:0] data_outB,
  output logic              clear_done,
  output logic [15:0]       stall_count
);
  typedef enum logic {CLEAR, RUN} state_e;
  typedef struct packed {
    logic [ADDR_W-1:0] rg;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic              prio_q;
  logic [1:0]        vld, rdy, xfer;
  wb_req_t [1:0]     req;
  wb_req_t           win;
  logic              stall;

  assign vld    = {req1_valid, req0_valid};
  assign req[0] = '{rg: req0_reg, data: req0_data};
  assign req[1] = '{rg: req1_reg, data: req1_data};

  always_comb begin
    state_d = state_q;
    rdy     = '0;
    case (state_q)
      CLEAR: if (cnt_q == ADDR_W'(NUM_REGS - 1)) state_d = RUN;
      RUN: begin
        if (vld == 2'b11) rdy[prio_q] = 1'b1;
        else              rdy = vld;
      end
      default: state_d = CLEAR;
    endcase
  end

  assign xfer       = vld & rdy;
  assign win        = req[xfer[1]];
  assign stall      = |(vld & ~rdy);
  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];
  assign clear_done = (state_q == RUN);

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q       <= CLEAR;
      cnt_q         <= '0;
      prio_q        <= 1'b0;
      ctrl_writeEn  <= 1'b0;
      ctrl_writeReg <= '0;
      data_writeReg <= '0;
      stall_count   <= '0;
    end else begin
      state_q <= state_d;
      if (stall && stall_count != '1) stall_count <= stall_count + 16'd1;
      if (state_q == CLEAR) begin
        ctrl_writeEn  <= 1'b1;
        ctrl_writeReg <= cnt_q;
        data_writeReg <= '0;
        cnt_q         <= cnt_q + 1'b1;
      end else if (|xfer) begin
        // winner k hands priority to the other side; r0 writes are swallowed
        prio_q       <= xfer[0];
        ctrl_writeEn <= (win.rg != '0);
        if (win.rg != '0) begin
          ctrl_writeReg <= win.rg;
          data_writeReg <= win.data;
        end
      end else begin
        ctrl_writeEn <= 1'b0;
      end
    end
  end

  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0][DATA_W-1:0] rd_raw, rd_out;
  assign rd_addr   = {ctrl_readRegB, ctrl_readRegA};
  assign rd_raw    = {data_readRegB, data_readRegA};
  assign data_outA = rd_out[0];
  assign data_outB = rd_out[1];

`ifdef REGFILE_WB_BYPASS_EN
  for (genvar p = 0; p < 2; p++) begin : g_byp
    assign rd_out[p] = (ctrl_writeEn && ctrl_writeReg == rd_addr[p] && rd_addr[p] != '0)
                       ? data_writeReg : rd_raw[p];
  end
`else
  logic unused_rd_addr;
  assign rd_out         = rd_raw;
  assign unused_rd_addr = ^rd_addr;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed checks of regfile_write_arbiter against a transaction-level model,
// with a behavioural regfile attached to the write and read ports.
module tb_regfile_write_arbiter;
  localparam int AW = 5, DW = 32, NR = 32;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock, ctrl_reset_n;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [AW-1:0] req0_reg, req1_reg, ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic [DW-1:0] req0_data, req1_data, data_writeReg;
  logic [DW-1:0] data_readRegA, data_readRegB, data_outA, data_outB;
  logic          ctrl_writeEn, clear_done;
  logic [15:0]   stall_count;

  int total = 0, bad = 0;

  regfile_write_arbiter #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
    .ctrl_writeEn(ctrl_writeEn), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .data_outA(data_outA), .data_outB(data_outB),
    .clear_done(clear_done), .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural regfile; scramble fills it with garbage while reset is held.
  logic [DW-1:0] rf [NR];
  logic          scramble;
  always @(posedge clock) begin
    if (scramble) for (int i = 0; i < NR; i++) rf[i] <= $urandom;
    else if (ctrl_writeEn) rf[ctrl_writeReg] <= data_writeReg;
  end
  assign data_readRegA = rf[ctrl_readRegA];
  assign data_readRegB = rf[ctrl_readRegB];

  // Model state
  bit            m_clear, m_prio, g0, g1;
  int            m_cnt, m_stall;
  logic [DW-1:0] mmem [NR];
  bit            mval [NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    ctrl_reset_n = 1'b0;
    scramble     = 1'b1;
    #1;
    chk("rst_writeEn",  32'(ctrl_writeEn), 32'd0);
    chk("rst_writeReg", 32'(ctrl_writeReg), 32'd0);
    chk("rst_writeData", data_writeReg, 32'd0);
    chk("rst_ready0",   32'(req0_ready), 32'd0);
    chk("rst_ready1",   32'(req1_ready), 32'd0);
    chk("rst_clear_done", 32'(clear_done), 32'd0);
    chk("rst_stall",    32'(stall_count), 32'd0);
    m_clear = 1'b1; m_cnt = 0; m_prio = 1'b0; m_stall = 0; g0 = 1'b0; g1 = 1'b0;
    for (int i = 0; i < NR; i++) mval[i] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    scramble     = 1'b0;
    ctrl_reset_n = 1'b1;
  endtask

  // One clock cycle: called just after a negedge once inputs are driven.
  task automatic tick();
    bit            e0, e1, stl, ew, hit;
    logic [AW-1:0] er;
    logic [DW-1:0] ed, ea, eb;
    #1;
    e0 = 1'b0; e1 = 1'b0;
    if (!m_clear) begin
      if (req0_valid && req1_valid) begin
        e0 = (m_prio == 1'b0);
        e1 = (m_prio == 1'b1);
      end else begin
        e0 = req0_valid;
        e1 = req1_valid;
      end
    end
    chk("ready0", 32'(req0_ready), 32'(e0));
    chk("ready1", 32'(req1_ready), 32'(e1));
    stl = (req0_valid && !e0) || (req1_valid && !e1);
    ew = 1'b0; er = '0; ed = '0;
    if (m_clear) begin
      ew = 1'b1; er = AW'(m_cnt); ed = '0;
      m_cnt++;
      if (m_cnt == NR) m_clear = 1'b0;
    end else if (e0 || e1) begin
      er     = e0 ? req0_reg : req1_reg;
      ed     = e0 ? req0_data : req1_data;
      ew     = (er != '0);
      m_prio = e0 ? 1'b1 : 1'b0;
    end
    if (stl && m_stall < 65535) m_stall++;
    g0 = e0; g1 = e1;
    @(posedge clock);
    #1;
    chk("writeEn", 32'(ctrl_writeEn), 32'(ew));
    if (ew) begin
      chk("writeReg", 32'(ctrl_writeReg), 32'(er));
      chk("writeData", data_writeReg, ed);
    end
    chk("clear_done", 32'(clear_done), 32'(!m_clear));
    chk("stall_count", 32'(stall_count), 32'(m_stall));
    hit = BYP && ew && er == ctrl_readRegA && ctrl_readRegA != '0;
    ea  = hit ? ed : mmem[ctrl_readRegA];
    if (hit || mval[ctrl_readRegA]) chk("outA", data_outA, ea);
    hit = BYP && ew && er == ctrl_readRegB && ctrl_readRegB != '0;
    eb  = hit ? ed : mmem[ctrl_readRegB];
    if (hit || mval[ctrl_readRegB]) chk("outB", data_outB, eb);
    if (ew) begin mmem[er] = ed; mval[er] = 1'b1; end
    @(negedge clock);
  endtask

  // Random requesters that respect the hold-until-transfer rule.
  task automatic drive_rand();
    if (!req0_valid || g0) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req0_reg   = AW'($urandom);
      req0_data  = $urandom;
    end
    if (!req1_valid || g1) begin
      req1_valid = ($urandom_range(0, 2) != 0);
      req1_reg   = AW'($urandom);
      req1_data  = $urandom;
    end
    ctrl_readRegA = AW'($urandom);
    ctrl_readRegB = AW'($urandom);
  endtask

  initial begin
    ctrl_reset_n = 1'b1; scramble = 1'b0;
    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'hC0FFEE05;
    req1_valid = 1'b0; req1_reg = '0;   req1_data = '0;
    ctrl_readRegA = '0; ctrl_readRegB = '0;
    #2;
    do_reset();

    // sweep with req0 held throughout, then its write lands on edge 33
    for (int i = 0; i < NR; i++) begin
      ctrl_readRegA = AW'($urandom); ctrl_readRegB = AW'($urandom);
      tick();
    end
    chk("stall_after_sweep", 32'(stall_count), 32'd32);
    tick();
    req0_valid = 1'b0;

    // one req1 write hands priority back to req0
    req1_valid = 1'b1; req1_reg = 5'd4; req1_data = 32'h04040404;
    tick();
    req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'h03030303;
    for (int i = 0; i < 6; i++) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // same destination: loser's value must persist
    req0_valid = 1'b1; req0_reg = 5'd7; req0_data = 32'hAAAAAAAA;
    req1_valid = 1'b1; req1_reg = 5'd7; req1_data = 32'h55555555;
    tick();
    req0_valid = 1'b0;
    tick();
    req1_valid = 1'b0;
    tick(); tick();
    ctrl_readRegA = 5'd7; #1;
    chk("reg7_final", data_outA, 32'h55555555);

    // register 0 is accepted but never written
    req0_valid = 1'b1; req0_reg = 5'd0; req0_data = 32'hFFFFFFFF;
    tick();
    req0_valid = 1'b0;
    tick();
    ctrl_readRegA = 5'd0; #1;
    chk("reg0_zero", data_outA, 32'h0);

    // read reg 9 in the write-enable cycle (bypass vs old value)
    req0_valid = 1'b1; req0_reg = 5'd9; req0_data = 32'h12345678;
    ctrl_readRegA = 5'd9; ctrl_readRegB = 5'd9;
    tick();
    req0_valid = 1'b0;
    tick();

    for (int i = 0; i < 400; i++) begin drive_rand(); tick(); end

    // reset in the middle of the sweep, right after register 15 is presented
    do_reset();
    for (int i = 0; i < 16; i++) begin drive_rand(); tick(); end
    do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < NR + 200; i++) begin drive_rand(); tick(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32x32 register file between two writeback requesters, e.g. ALU writeback and load/mult-div writeback. It uses a valid/ready handshake with round-robin arbitration. After every reset it sequences a zero-clear sweep of all registers before it accepts any request. It sits between the writeback stage and the regfile's `ctrl_writeEn`/`ctrl_writeReg`/`data_writeReg` inputs, and optionally bypasses in-flight write data onto the read ports.

## Interface
- `NUM_REGS`, 32: number of registers to sweep; must equal 2^`ADDR_W`.
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: data width.

Ports:
- `clock`  in  1  rising-edge clock.
- `ctrl_reset_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  write request.
- `req0_ready` / `req1_ready`  out  1  grant. Transfer occurs when valid && ready at a rising edge.
- `req0_reg` / `req1_reg`  in  `ADDR_W`  destination register.
- `req0_data` / `req1_data`  in  `DATA_W`  write data.
- `ctrl_writeEn`  out  1  registered regfile write enable.
- `ctrl_writeReg`  out  `ADDR_W`  registered regfile write address.
- `data_writeReg`  out  `DATA_W`  registered regfile write data.
- `ctrl_readRegA` / `ctrl_readRegB`  in  `ADDR_W`  read addresses, also driven to the regfile.
- `data_readRegA` / `data_readRegB`  in  `DATA_W`  raw regfile read data.
- `data_outA` / `data_outB`  out  `DATA_W`  read data delivered to the datapath.
- `clear_done`  out  1  high when in the RUN state.
- `stall_count`  out  16  saturating count of stall cycles.

## Operation
- Two states: CLEAR and RUN. Reset enters CLEAR with sweep counter `cnt`=0.
- CLEAR:
  - At each rising edge, register `ctrl_writeEn`=1, `ctrl_writeReg`=`cnt`, `data_writeReg`=0, then `cnt`++.
  - When `cnt`==`NUM_REGS`-1 is issued, go to RUN.
  - Both readys are 0 throughout.
- RUN, readys are combinational from the valids and the `prio` bit (reset 0, favouring req0):
  - Only one valid: that requester is ready.
  - Both valid: requester `prio` is ready, the other is held.
  - Neither valid: both readys are 0.
- Every transfer from requester k sets `prio` to ~k, whether contested or not.
- Accepted transfer:
  - At that edge, register `ctrl_writeEn`=1 with the winner's reg and data.
  - A cycle with no transfer registers `ctrl_writeEn`=0; reg and data hold their last values.
- Register 0: a request is accepted (ready is asserted and the transfer completes), but `ctrl_writeEn` stays 0 and `prio` still updates.
- Both requesters targeting the same register: the winner writes first and the loser writes on the following accepted cycle, so the loser's value persists.
- `stall_count`:
  - Increments by 1 on each edge where at least one valid requester is not ready, in either state.
  - Saturates at 0xFFFF and clears only on reset.
- Requesters must hold valid, reg and data stable until the transfer. The arbiter does not check this.

## Timing
- Reset values, applied immediately while `ctrl_reset_n`=0:
  - `ctrl_writeEn`=0, `ctrl_writeReg`=0, `data_writeReg`=0.
  - `req0_ready`/`req1_ready`=0, `clear_done`=0, `stall_count`=0.
  - State CLEAR, `cnt`=0, `prio`=0.
- Sweep: rising edges 1..32 after reset release present register 0..31 with data 0. State becomes RUN at edge 32.
  - `clear_done`=1 and ready are available in the cycle after edge 32.
  - The first request write appears at edge 33, with no bubble.
- Latency: transfer at edge N puts `ctrl_writeEn`=1 in cycle N..N+1. The regfile commits the write at edge N+1.
- Throughput: one write per cycle. `ctrl_writeEn` is high for exactly one cycle per accepted non-zero write.
- Reset asserted mid-sweep or mid-RUN: outputs go to reset values asynchronously. The sweep restarts from register 0 after release. Requests pending at reset are dropped.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined: `data_outA` = `data_writeReg` when `ctrl_writeEn`=1, `ctrl_writeReg`==`ctrl_readRegA` and `ctrl_readRegA`!=0; otherwise `data_readRegA`. Port B uses the same rule. The bypass is combinational.
- `REGFILE_WB_BYPASS_EN` not defined: `data_outA`=`data_readRegA` and `data_outB`=`data_readRegB`, a pure passthrough.

## Test plan
- Reset then release, no requests -> `ctrl_writeEn`=1 for exactly 32 edges, `ctrl_writeReg` 0..31 with data 0, then `clear_done`=1. Reading any register returns 0x00000000.
- `req0_valid` held through the sweep -> `req0_ready`=0 until `clear_done`, `stall_count`=32, and the write lands at edge 33.
- Both valid every cycle, req0 to reg 3 with 0x03030303 and req1 to reg 4 with 0x04040404 -> grants alternate req0, req1, req0. `ctrl_writeEn` is continuous, `stall_count` increments by 1 per cycle.
- Both target reg 7, req0=0xAAAAAAAA and req1=0x55555555 with `prio`=0 -> reg 7 ends as 0x55555555.
- Request to reg 0 with 0xFFFFFFFF -> ready=1, `ctrl_writeEn` stays 0, reg 0 reads 0.
- With `REGFILE_WB_BYPASS_EN`, write reg 9=0x12345678 and read reg 9 in the `ctrl_writeEn` cycle -> `data_outA`=`data_outB`=0x12345678. Without the macro, the old value is read.
- Assert `ctrl_reset_n`=0 mid-sweep at register 15 -> outputs clear immediately and the sweep restarts at register 0.
